// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: one 32-bit load/store as two half-word phases on a 16-bit async SRAM.
// Optional macro SRAM_POSTED_WRITE_EN: stores are accepted without a freeze and finish in the background.
module sram_mem_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        op_wr_r;
  logic [15:0] wdata_hi_r;
  logic [15:0] dq_out_r;
  logic        dq_oe_r;
  logic        req_s;
  logic        posted_s;
  logic        last_s;
  logic [31:0] offset_s;
  logic        unused_s;

  assign req_s    = rd_en | wr_en;
  assign offset_s = address - ADDR_BASE;
  assign last_s   = (cnt_r == LAST_CNT);
  assign unused_s = ^{offset_s[31:19], offset_s[1:0]};

`ifdef SRAM_POSTED_WRITE_EN
  assign posted_s = (state_r == IDLE) && wr_en;
`else
  assign posted_s = 1'b0;
`endif

  assign ready     = (state_r == DONE) || !req_s || posted_s;
  assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Phase sequencer; SRAM pins are registered one edge ahead of the cycle they apply to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      op_wr_r    <= 1'b0;
      wdata_hi_r <= 16'd0;
      dq_out_r   <= 16'd0;
      dq_oe_r    <= 1'b0;
      read_data  <= 32'd0;
      SRAM_ADDR  <= 18'd0;
      SRAM_WE_N  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            op_wr_r    <= wr_en;
            wdata_hi_r <= write_data[31:16];
            dq_out_r   <= write_data[15:0];
            dq_oe_r    <= wr_en;
            SRAM_ADDR  <= {offset_s[18:2], 1'b0};
            SRAM_WE_N  <= !(wr_en && (LAST_CNT != 4'd0));
            cnt_r      <= 4'd0;
            state_r    <= LOW;
          end else begin
            state_r <= IDLE;
          end
        end
        LOW: begin
          if (last_s) begin
            if (!op_wr_r) read_data[15:0] <= SRAM_DQ;
            SRAM_ADDR[0] <= 1'b1;
            dq_out_r     <= wdata_hi_r;
            SRAM_WE_N    <= !(op_wr_r && (LAST_CNT != 4'd0));
            cnt_r        <= 4'd0;
            state_r      <= HIGH;
          end else begin
            // WE_N rises for the final cycle of the phase while data is still driven
            SRAM_WE_N <= !(op_wr_r && ((cnt_r + 4'd1) != LAST_CNT));
            cnt_r     <= cnt_r + 4'd1;
          end
        end
        HIGH: begin
          if (last_s) begin
            if (!op_wr_r) read_data[31:16] <= SRAM_DQ;
            SRAM_WE_N <= 1'b1;
            dq_oe_r   <= 1'b0;
            cnt_r     <= 4'd0;
`ifdef SRAM_POSTED_WRITE_EN
            state_r   <= op_wr_r ? IDLE : DONE;
`else
            state_r   <= DONE;
`endif
          end else begin
            SRAM_WE_N <= !(op_wr_r && ((cnt_r + 4'd1) != LAST_CNT));
            cnt_r     <= cnt_r + 4'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 4'd0;
          dq_oe_r   <= 1'b0;
          SRAM_WE_N <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: directed and random loads/stores against a word-level reference memory.
// A half-word SRAM model sits on the bus; expectations follow the block's timing rules for W=2.
module tb_sram_mem_ctrl;
  localparam int W   = 2;
  localparam int LAT = 1 + 2 * W;
`ifdef SRAM_POSTED_WRITE_EN
  localparam int WR_LAT  = 0;
  localparam int WR_IDLE = 2 * W;
  localparam int B2B     = 2 + 2 * W;
`else
  localparam int WR_LAT  = LAT;
  localparam int WR_IDLE = 0;
  localparam int B2B     = 3 + 4 * W;
`endif

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, ce_n, oe_n, ub_n, lb_n;

  logic [15:0] sram [0:262143];
  logic        sram_drive, probe_en, pre_we;
  logic [17:0] pre_a;
  logic [15:0] pre_d;
  logic [31:0] ref_mem [int];
  logic [31:0] last_read;
  logic [17:0] wlog_a [$];
  logic [15:0] wlog_d [$];
  int          cyc = 0;
  int          checks, errors;

  sram_mem_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq = sram_drive ? sram[sram_addr] : (probe_en ? 16'hA5C3 : 16'hzzzz);

  // SRAM model: level-sensitive write sampled mid-cycle, plus a backdoor preload port
  always @(negedge clk) begin
    if (we_n === 1'b0) begin
      sram[sram_addr] <= sram_dq;
      wlog_a.push_back(sram_addr);
      wlog_d.push_back(sram_dq);
    end else if (pre_we) begin
      sram[pre_a] <= pre_d;
    end
  end

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return int'(o[18:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [17:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(negedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Called at posedge+1; returns the cycle in which ready was seen high, ends at posedge+1 idle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int done);
    sram_drive = rd && !wr;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    done = -1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        done = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0; sram_drive = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, output int done);
    int t0;
    logic [31:0] exp;
    t0 = cyc;
    access(1'b1, 1'b0, a, 32'h0, done);
    check({tag, "_lat"}, done - t0, LAT);
    exp = ref_mem[word_of(a)];
    check({tag, "_data"}, read_data, exp);
    last_read = exp;
  endtask

  task automatic do_store(input string tag, input logic both, input logic [31:0] a,
                          input logic [31:0] d, output int done);
    int t0;
    wlog_a.delete(); wlog_d.delete();
    t0 = cyc;
    access(both, 1'b1, a, d, done);
    check({tag, "_lat"}, done - t0, WR_LAT);
    repeat (WR_IDLE) begin @(posedge clk); #1; end
    check({tag, "_rdata_kept"}, read_data, last_read);
    ref_mem[word_of(a)] = d;
  endtask

  initial begin
    int done, t0, k;
    logic [31:0] a, d, old;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
    sram_drive = 1'b0; probe_en = 1'b0; pre_we = 1'b0; pre_a = 18'd0; pre_d = 16'd0;
    checks = 0; errors = 0; last_read = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, we_n}, 32'd1);
    check("rst_rdata", read_data, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    probe_en = 1'b1; #1;
    check("rst_bus", {16'd0, sram_dq}, 32'h0000A5C3);
    probe_en = 1'b0;

    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      poke(18'(2 * i), d[15:0]);
      poke(18'(2 * i + 1), d[31:16]);
      ref_mem[i] = d;
    end
    poke(18'd2, 16'h5678);
    poke(18'd3, 16'h1234);
    ref_mem[1] = 32'h12345678;
    rst = 1'b0;
    @(posedge clk); #1;

    do_store("st_deadbeef", 1'b0, 32'd1024, 32'hDEADBEEF, done);
    check("st_log_n", wlog_a.size(), 32'd2);
    check("st_log0_a", {14'd0, wlog_a[0]}, 32'd0);
    check("st_log0_d", {16'd0, wlog_d[0]}, 32'h0000BEEF);
    check("st_log1_a", {14'd0, wlog_a[1]}, 32'd1);
    check("st_log1_d", {16'd0, wlog_d[1]}, 32'h0000DEAD);

    do_load("ld_1028", 32'd1028, done);
    check("ld_1028_const", read_data, 32'h12345678);

    t0 = cyc;
    do_load("b2b_ld", 32'd1024, done);
    do_store("b2b_st", 1'b0, 32'd1036, 32'hCAFEF00D, done);
    check("b2b_done", done - t0, B2B);
    check("b2b_rdata", read_data, 32'hDEADBEEF);

    do_store("both_en", 1'b1, 32'd1040, 32'h0BADC0DE, done);
    do_load("both_rb", 32'd1040, done);

    do_store("wrap_st", 1'b0, 32'd1020, 32'h13579BDF, done);
    check("wrap_a0", {14'd0, wlog_a[0]}, 32'h0003FFFE);
    check("wrap_a1", {14'd0, wlog_a[1]}, 32'h0003FFFF);
    do_load("wrap_ld", 32'd1023, done);

    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 15));
      a = 32'd1024 + 32'(4 * k) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_store("rnd_st", 1'b0, a, $urandom, done);
      else do_load("rnd_ld", a, done);
    end

    a = 32'd1044; old = ref_mem[5]; d = $urandom;
    wr_en = 1'b1; address = a; write_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_high_we_low", {31'd0, we_n}, 32'd0);
    rst = 1'b1; #1;
    check("mid_rst_we_n", {31'd0, we_n}, 32'd1);
    check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
    rst = 1'b0; probe_en = 1'b1; #1;
    check("mid_rst_bus", {16'd0, sram_dq}, 32'h0000A5C3);
    probe_en = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_rdata", read_data, 32'd0);
    @(posedge clk); #1;
    ref_mem[5] = {old[31:16], d[15:0]};
    last_read = 32'd0;
    do_load("after_rst", a, done);

`ifdef SRAM_POSTED_WRITE_EN
    a = 32'd1052; d = $urandom; t0 = cyc;
    wr_en = 1'b1; address = a; write_data = d;
    @(negedge clk);
    check("pw_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b1;
    done = -1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        done = cyc;
        break;
      end
      @(posedge clk); #1;
      if (cyc - t0 >= 2 * W + 1) sram_drive = 1'b1;
    end
    check("pw_load_done", done - t0, 32'(2 * LAT));
    ref_mem[word_of(a)] = d;
    check("pw_load_data", read_data, d);
    @(posedge clk); #1;
    rd_en = 1'b0; sram_drive = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-stage controller that sequences one 32-bit load or store from the EXE/MEM pipeline register onto a 16-bit asynchronous external SRAM as two half-word accesses. It sits between the EXE/MEM register outputs (MEM_R_EN, MEM_W_EN, ALU_result, ST_val) and the SRAM pins. Its `ready` output, inverted, is the pipeline-wide freeze that holds every stage register until the access completes.

## Interface
- `WAIT_CYCLES`, default 2: clock cycles per half-word SRAM phase; legal range 1–15.
- `ADDR_BASE`, default 32'd1024: byte address that maps to SRAM word 0.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rd_en` input 1: load request (MEM_R_EN).
- `wr_en` input 1: store request (MEM_W_EN).
- `address` input 32: byte address (ALU_result).
- `write_data` input 32: store data (ST_val).
- `read_data` output 32: load result, registered.
- `ready` output 1: combinational; 0 means freeze the pipeline.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` output 18: SRAM half-word address.
- `SRAM_WE_N` output 1: SRAM write enable, active-low.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N` output 1 each: tied to 0.

## Operation
- States: IDLE, LOW, HIGH, DONE. A 4-bit phase counter `cnt` counts 0..WAIT_CYCLES-1 inside LOW and HIGH.
- IDLE, request present (`rd_en|wr_en`):
  - Capture `address - ADDR_BASE`, `write_data`, and the operation into internal registers.
  - Go to LOW with `cnt` = 0.
  - If both enables are high, the access is a write; `read_data` is unchanged.
- LOW:
  - `SRAM_ADDR` = {offset[18:2], 1'b0}.
  - Stays WAIT_CYCLES cycles, then goes to HIGH with `cnt` = 0.
  - Read: `SRAM_DQ` is latched into `read_data[15:0]` on the last LOW cycle.
- HIGH:
  - `SRAM_ADDR` = {offset[18:2], 1'b1}.
  - Stays WAIT_CYCLES cycles, then goes to DONE.
  - Read: `SRAM_DQ` is latched into `read_data[31:16]` on the last HIGH cycle.
- DONE: `ready` = 1 for exactly one cycle, then unconditional transition to IDLE.
- Write phases: `SRAM_WE_N` = 0 and `SRAM_DQ` driven with the half-word on every LOW/HIGH cycle except the last cycle of each phase. On those last cycles `SRAM_WE_N` = 1 with data still driven, giving data hold on the WE_N rising edge.
- `SRAM_DQ` is high-Z in all other cycles and for all reads.
- `ready` = 0 when a request is present and state ≠ DONE; otherwise 1.
- Offset arithmetic is 32-bit unsigned and wraps. Only offset[18:2] is used, so address bits [1:0] are ignored (word-aligned access).
- `read_data` holds its value until the next read overwrites it.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `read_data` 0, `SRAM_ADDR` 0, `SRAM_WE_N` 1, `SRAM_DQ` high-Z.
  - `ready` = !(`rd_en`|`wr_en`).
- Blocking access latency: request seen at cycle 0 → `ready` = 1 at cycle 1+2·WAIT_CYCLES.
  - WAIT_CYCLES=2: `ready` is low for 5 cycles and high at cycle 5.
  - `read_data` is valid from cycle 1+2·WAIT_CYCLES.
- Back-to-back accesses: DONE → IDLE costs one cycle. A second access sees its request in IDLE at cycle 2+2W and completes at cycle 3+4W.
- `rst` asserted mid-access: immediate return to IDLE, `SRAM_WE_N` = 1, bus released. The partial write is not completed.
- Request inputs changing mid-access (illegal while frozen) have no effect; the captured registers are used.

## Configuration
- `SRAM_POSTED_WRITE_EN` defined:
  - A write accepted in IDLE gives `ready` = 1 in that same cycle (no freeze). The write then completes in the background.
  - A posted write goes HIGH → IDLE, skipping DONE.
  - Any request seen while state is LOW or HIGH drives `ready` = 0 until IDLE is reached, then is handled normally.
  - Reads always block.
- Not defined: writes block exactly like reads (1+2W freeze cycles, via DONE).

## Test plan
- Reset with `rd_en` = 0 → `ready` = 1, `SRAM_WE_N` = 1, `SRAM_DQ` high-Z, `read_data` = 0.
- Store `address` = 1024, `write_data` = 0xDEADBEEF, W=2:
  - SRAM model receives 0xBEEF at address 0, then 0xDEAD at address 1.
  - `ready` is low for 5 cycles.
- Load `address` = 1028 with the SRAM model holding 0x5678 at address 2 and 0x1234 at address 3 → `read_data` = 0x12345678 at cycle 5.
- Load then store back-to-back → second access completes at cycle 11. `read_data` is unchanged by the store.
- `rst` pulsed during the HIGH phase of a store → IDLE next edge, `SRAM_WE_N` = 1; a following load returns correct data.
- With `SRAM_POSTED_WRITE_EN`: store, then a load one cycle later:
  - Store cycle has `ready` = 1.
  - Load is stalled until IDLE at cycle 5, then completes 5 cycles later with correct data.
